// File: rtl/npu_seq_ctrl.sv
// npu_seq_ctrl: NPU invocation sequencer.
// Holds per-context input/output count targets. These are loaded only while in CONFIG.
// Each invocation reads N inputs, then writes M outputs, and ends with a one-cycle inv_done pulse.
// Optional feature macro: NPU_SEQ_PERF_EN adds saturating stall-cycle and invocation counters.
module npu_seq_ctrl #(
   parameter int CNT_W  = 16,
   parameter int DATA_W = 16,
   parameter int CTX_W  = 2
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [DATA_W-1:0] cfg_data,
   input  logic [CTX_W-1:0]  cfg_ctx,
   input  logic              cfg_in_we,
   input  logic              cfg_out_we,
   input  logic              cfg_fifo_empty,
   input  logic [CTX_W-1:0]  inv_ctx,
   input  logic              in_fifo_empty,
   input  logic              sched_in_rd_req,
   input  logic              out_fifo_full,
   input  logic              sched_out_wr_req,
   output logic              in_fifo_rd_en,
   output logic              out_fifo_wr_en,
   output logic              state_idle,
   output logic              state_config,
   output logic              state_compute,
   output logic              state_stall,
   output logic              inputs_done,
   output logic              inv_done,
`ifdef NPU_SEQ_PERF_EN
   output logic [31:0]       perf_stall_cycles,
   output logic [31:0]       perf_inv_count,
`endif
   output logic [CTX_W-1:0]  active_ctx
);

   localparam int NUM_CTX = 2 ** CTX_W;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef enum logic [2:0] {
      S_IDLE, S_CONFIG, S_LOAD, S_DRAIN, S_STALL_IN, S_STALL_OUT
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] in_cur_q, in_cur_d, out_cur_q, out_cur_d;
   logic [CNT_W-1:0] in_tgt_q, in_tgt_d, out_tgt_q, out_tgt_d;
   logic [CTX_W-1:0] active_ctx_q, active_ctx_d;
   logic             inputs_done_q, inputs_done_d;
   logic [CNT_W-1:0] in_tgt_mem_q  [NUM_CTX];
   logic [CNT_W-1:0] in_tgt_mem_d  [NUM_CTX];
   logic [CNT_W-1:0] out_tgt_mem_q [NUM_CTX];
   logic [CNT_W-1:0] out_tgt_mem_d [NUM_CTX];
   logic             rd_en, wr_en, inv_done_c;
   logic [CNT_W-1:0] cfg_val;

   assign cfg_val = cfg_data[CNT_W-1:0];

   // Next-state, counter, target-table and strobe logic. The cur != tgt gating keeps the counters from wrapping.
   always_comb begin
      state_d       = state_q;
      in_cur_d      = in_cur_q;
      out_cur_d     = out_cur_q;
      in_tgt_d      = in_tgt_q;
      out_tgt_d     = out_tgt_q;
      active_ctx_d  = active_ctx_q;
      inputs_done_d = inputs_done_q;
      in_tgt_mem_d  = in_tgt_mem_q;
      out_tgt_mem_d = out_tgt_mem_q;
      rd_en         = 1'b0;
      wr_en         = 1'b0;
      inv_done_c    = 1'b0;
      case (state_q)
         S_IDLE: begin
            // A pending invocation wins over pending configuration.
            if (!in_fifo_empty) begin
               state_d      = S_LOAD;
               active_ctx_d = inv_ctx;
               in_tgt_d     = in_tgt_mem_q[inv_ctx];
               out_tgt_d    = out_tgt_mem_q[inv_ctx];
               in_cur_d     = '0;
               out_cur_d    = '0;
            end else if (!cfg_fifo_empty) begin
               state_d = S_CONFIG;
            end
         end
         S_CONFIG: begin
            if (cfg_in_we)  in_tgt_mem_d[cfg_ctx]  = cfg_val;
            if (cfg_out_we) out_tgt_mem_d[cfg_ctx] = cfg_val;
            if (cfg_fifo_empty) state_d = S_IDLE;
         end
         S_LOAD: begin
            rd_en = sched_in_rd_req && !in_fifo_empty && (in_cur_q != in_tgt_q);
            if (rd_en) in_cur_d = in_cur_q + CNT_ONE;
            if ((in_cur_q == in_tgt_q) || (rd_en && ((in_cur_q + CNT_ONE) == in_tgt_q))) begin
               state_d       = S_DRAIN;
               inputs_done_d = 1'b1;
            end else if (in_fifo_empty) begin
               state_d = S_STALL_IN;
            end
         end
         S_STALL_IN: begin
            if (!in_fifo_empty) state_d = S_LOAD;
         end
         S_DRAIN: begin
            wr_en = sched_out_wr_req && !out_fifo_full && (out_cur_q != out_tgt_q);
            if (wr_en) out_cur_d = out_cur_q + CNT_ONE;
            if ((out_cur_q == out_tgt_q) || (wr_en && ((out_cur_q + CNT_ONE) == out_tgt_q))) begin
               state_d       = S_IDLE;
               inv_done_c    = 1'b1;
               inputs_done_d = 1'b0;
            end else if (sched_out_wr_req && out_fifo_full) begin
               state_d = S_STALL_OUT;
            end
         end
         S_STALL_OUT: begin
            if (!out_fifo_full) state_d = S_DRAIN;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State, counters, latched targets and the per-context target table. Reset clears everything.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q       <= S_IDLE;
         in_cur_q      <= '0;
         out_cur_q     <= '0;
         in_tgt_q      <= '0;
         out_tgt_q     <= '0;
         active_ctx_q  <= '0;
         inputs_done_q <= 1'b0;
         for (int i = 0; i < NUM_CTX; i++) begin
            in_tgt_mem_q[i]  <= '0;
            out_tgt_mem_q[i] <= '0;
         end
      end else begin
         state_q       <= state_d;
         in_cur_q      <= in_cur_d;
         out_cur_q     <= out_cur_d;
         in_tgt_q      <= in_tgt_d;
         out_tgt_q     <= out_tgt_d;
         active_ctx_q  <= active_ctx_d;
         inputs_done_q <= inputs_done_d;
         in_tgt_mem_q  <= in_tgt_mem_d;
         out_tgt_mem_q <= out_tgt_mem_d;
      end
   end

`ifdef NPU_SEQ_PERF_EN
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   logic [31:0] perf_stall_q, perf_stall_d, perf_inv_q, perf_inv_d;

   // Saturating performance counters: stall cycles and completed invocations.
   always_comb begin
      perf_stall_d = perf_stall_q;
      perf_inv_d   = perf_inv_q;
      if ((state_q == S_STALL_IN) || (state_q == S_STALL_OUT)) perf_stall_d = sat_inc(perf_stall_q);
      if (inv_done_c) perf_inv_d = sat_inc(perf_inv_q);
   end

   // Performance counter registers; cleared only by reset.
   always_ff @(posedge CLK) begin
      if (RST) begin
         perf_stall_q <= '0;
         perf_inv_q   <= '0;
      end else begin
         perf_stall_q <= perf_stall_d;
         perf_inv_q   <= perf_inv_d;
      end
   end

   assign perf_stall_cycles = perf_stall_q;
   assign perf_inv_count    = perf_inv_q;
`endif

   assign in_fifo_rd_en  = rd_en;
   assign out_fifo_wr_en = wr_en;
   assign inv_done       = inv_done_c;
   assign inputs_done    = inputs_done_q;
   assign active_ctx     = active_ctx_q;
   assign state_idle     = (state_q == S_IDLE);
   assign state_config   = (state_q == S_CONFIG);
   assign state_compute  = (state_q == S_LOAD) || (state_q == S_DRAIN);
   assign state_stall    = (state_q == S_STALL_IN) || (state_q == S_STALL_OUT);

endmodule

// File: tb/tb_npu_seq_ctrl.sv
// Scoreboard testbench for npu_seq_ctrl.
// Stimulus pushes the expected rd/wr/done events into a queue.
// A negedge monitor pops that queue and compares each time the DUT strobes an output.
`timescale 1ns/1ps
module tb_npu_seq_ctrl;
   localparam int CNT_W  = 16;
   localparam int DATA_W = 16;
   localparam int CTX_W  = 2;

   logic              CLK = 1'b0;
   logic              RST;
   logic [DATA_W-1:0] cfg_data;
   logic [CTX_W-1:0]  cfg_ctx;
   logic              cfg_in_we, cfg_out_we, cfg_fifo_empty;
   logic [CTX_W-1:0]  inv_ctx;
   logic              in_fifo_empty, sched_in_rd_req, out_fifo_full, sched_out_wr_req;
   logic              in_fifo_rd_en, out_fifo_wr_en;
   logic              state_idle, state_config, state_compute, state_stall;
   logic              inputs_done, inv_done;
   logic [CTX_W-1:0]  active_ctx;
`ifdef NPU_SEQ_PERF_EN
   logic [31:0]       perf_stall_cycles, perf_inv_count;
`endif

   npu_seq_ctrl #(.CNT_W(CNT_W), .DATA_W(DATA_W), .CTX_W(CTX_W)) dut (
      .CLK              (CLK),
      .RST              (RST),
      .cfg_data         (cfg_data),
      .cfg_ctx          (cfg_ctx),
      .cfg_in_we        (cfg_in_we),
      .cfg_out_we       (cfg_out_we),
      .cfg_fifo_empty   (cfg_fifo_empty),
      .inv_ctx          (inv_ctx),
      .in_fifo_empty    (in_fifo_empty),
      .sched_in_rd_req  (sched_in_rd_req),
      .out_fifo_full    (out_fifo_full),
      .sched_out_wr_req (sched_out_wr_req),
      .in_fifo_rd_en    (in_fifo_rd_en),
      .out_fifo_wr_en   (out_fifo_wr_en),
      .state_idle       (state_idle),
      .state_config     (state_config),
      .state_compute    (state_compute),
      .state_stall      (state_stall),
      .inputs_done      (inputs_done),
      .inv_done         (inv_done),
`ifdef NPU_SEQ_PERF_EN
      .perf_stall_cycles(perf_stall_cycles),
      .perf_inv_count   (perf_inv_count),
`endif
      .active_ctx       (active_ctx)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [1:0]       kind;   // 0 = read, 1 = write, 2 = done
      logic [CTX_W-1:0] ctx;
      logic             idone;
   } ev_t;

   ev_t sb[$];
   int  checks = 0;
   int  errors = 0;
   int  exp_perf_stall = 0;
   int  exp_perf_inv   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic push_ev(input logic [1:0] kind, input int ctx, input logic idone);
      ev_t e;
      e.kind  = kind;
      e.ctx   = CTX_W'(ctx);
      e.idone = idone;
      sb.push_back(e);
   endtask

   task automatic mon_ev(input logic [1:0] kind);
      ev_t act, exp;
      act.kind  = kind;
      act.ctx   = active_ctx;
      act.idone = inputs_done;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL unexpected_event actual=%0h required=none", act);
      end else begin
         exp = sb.pop_front();
         if (act !== exp) begin
            errors++;
            $display("FAIL event actual=%0h required=%0h", act, exp);
         end
      end
   endtask

   // Monitor: compare every strobe of the DUT against the head of the scoreboard.
   always @(negedge CLK) begin
      if (!RST) begin
         if (in_fifo_rd_en)  mon_ev(2'd0);
         if (out_fifo_wr_en) mon_ev(2'd1);
         if (inv_done)       mon_ev(2'd2);
      end
   end

   // Called from posedge+1 while in IDLE; returns in IDLE.
   task automatic do_config(input int ctx, input int vin, input int vout);
      cfg_fifo_empty = 1'b0;
      @(posedge CLK); #1;
      check("cfg_enter", state_config, 1'b1);
      cfg_ctx   = CTX_W'(ctx);
      cfg_data  = DATA_W'(vin);
      cfg_in_we = 1'b1;
      @(posedge CLK); #1;
      cfg_in_we      = 1'b0;
      cfg_out_we     = 1'b1;
      cfg_data       = DATA_W'(vout);
      cfg_fifo_empty = 1'b1;
      @(posedge CLK); #1;
      cfg_out_we = 1'b0;
      check("cfg_exit_idle", state_idle, 1'b1);
   endtask

   // One invocation, driven from IDLE at posedge+1. The FIFO models may stall after a given
   // read or write count. abort_wr > 0 asserts RST after that many writes.
   task automatic run_inv(input int ctx, input int n_in, input int n_out,
                          input int stall_after, input int stall_len,
                          input int full_after, input int full_len,
                          input int exp_stall, input int exp_load,
                          input bit cfg_pending, input int abort_wr);
      int rd_seen = 0, wr_seen = 0, stall_left = 0, full_left = 0;
      int cyc = 0, stall_cnt = 0, load_cnt = 0;
      bit done = 0, aborted = 0, idone = 0;
      for (int i = 0; i < n_in; i++) push_ev(2'd0, ctx, 1'b0);
      for (int i = 0; i < ((abort_wr > 0) ? abort_wr : n_out); i++) push_ev(2'd1, ctx, 1'b1);
      if (abort_wr == 0) push_ev(2'd2, ctx, 1'b1);
      // Stray config writes outside CONFIG must have no effect.
      cfg_ctx          = CTX_W'(ctx);
      cfg_data         = 16'h0009;
      cfg_in_we        = 1'b1;
      cfg_out_we       = 1'b1;
      inv_ctx          = CTX_W'(ctx);
      in_fifo_empty    = 1'b0;
      out_fifo_full    = 1'b0;
      sched_in_rd_req  = 1'b1;
      sched_out_wr_req = 1'b1;
      if (cfg_pending) cfg_fifo_empty = 1'b0;
      while (!done && !aborted && cyc < 200) begin
         @(negedge CLK);
         if (cyc == 1) begin
            check("load_entered", state_compute, 1'b1);
            check("no_config_first", state_config, 1'b0);
         end
         cyc++;
         if (in_fifo_rd_en) begin
            rd_seen++;
            if (rd_seen == stall_after) stall_left = stall_len;
         end
         if (out_fifo_wr_en) begin
            wr_seen++;
            if (wr_seen == full_after) full_left = full_len;
            if (wr_seen == abort_wr) aborted = 1;
         end
         if (inv_done) done = 1;
         if (state_stall) stall_cnt++;
         if (state_compute && !inputs_done) load_cnt++;
         if (inputs_done) idone = 1;
         @(posedge CLK); #1;
         if (aborted) begin
            RST              = 1'b1;
            sched_in_rd_req  = 1'b0;
            sched_out_wr_req = 1'b0;
            in_fifo_empty    = 1'b1;
         end else begin
            in_fifo_empty = (stall_left > 0) || idone;
            if (stall_left > 0) stall_left--;
            out_fifo_full = (full_left > 0);
            if (full_left > 0) full_left--;
         end
      end
      cfg_in_we        = 1'b0;
      cfg_out_we       = 1'b0;
      in_fifo_empty    = 1'b1;
      out_fifo_full    = 1'b0;
      sched_in_rd_req  = 1'b0;
      sched_out_wr_req = 1'b0;
      if (!done && !aborted) begin
         errors++;
         $display("FAIL timeout actual=%0d cycles required=completion", cyc);
      end
      check("sb_empty", sb.size(), 0);
      check("stall_cycles", stall_cnt, exp_stall);
      check("load_cycles", load_cnt, exp_load);
      if (!aborted) begin
         check("back_idle", state_idle, 1'b1);
         exp_perf_stall += exp_stall;
         exp_perf_inv   += 1;
`ifdef NPU_SEQ_PERF_EN
         check("perf_stall", perf_stall_cycles, exp_perf_stall);
         check("perf_inv", perf_inv_count, exp_perf_inv);
`endif
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      RST = 1'b1; cfg_data = '0; cfg_ctx = '0; cfg_in_we = 1'b0; cfg_out_we = 1'b0;
      cfg_fifo_empty = 1'b1; inv_ctx = '0; in_fifo_empty = 1'b1; sched_in_rd_req = 1'b0;
      out_fifo_full = 1'b0; sched_out_wr_req = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      check("rst_idle", state_idle, 1'b1);
      check("rst_config", state_config, 1'b0);
      check("rst_compute", state_compute, 1'b0);
      check("rst_stall", state_stall, 1'b0);
      check("rst_inputs_done", inputs_done, 1'b0);
      check("rst_inv_done", inv_done, 1'b0);
      check("rst_rd_en", in_fifo_rd_en, 1'b0);
      check("rst_wr_en", out_fifo_wr_en, 1'b0);
      check("rst_active_ctx", active_ctx, 0);
      RST = 1'b0;
      @(posedge CLK); #1;

      // Basic invocation on ctx1 (3 in, 2 out).
      do_config(1, 3, 2);
      run_inv(1, 3, 2, 0, 0, 0, 0, 0, 3, 1'b0, 0);
      // Input FIFO empty for 4 cycles after the first read.
      run_inv(1, 3, 2, 1, 4, 0, 0, 4, 4, 1'b0, 0);
      // Output FIFO full for 3 cycles after the first write.
      run_inv(1, 3, 2, 0, 0, 1, 3, 3, 3, 1'b0, 0);
      // Zero targets on ctx2.
      do_config(2, 0, 0);
      run_inv(2, 0, 0, 0, 0, 0, 0, 0, 1, 1'b0, 0);
      // Invocation has priority over pending config; CONFIG follows.
      run_inv(1, 3, 2, 0, 0, 0, 0, 0, 3, 1'b1, 0);
      @(posedge CLK); #1;
      check("cfg_after_inv", state_config, 1'b1);
      cfg_ctx = 2'd3; cfg_data = 16'd5; cfg_in_we = 1'b1; cfg_out_we = 1'b1; cfg_fifo_empty = 1'b1;
      @(posedge CLK); #1;
      check("cfg_both_exit", state_idle, 1'b1);
      cfg_in_we = 1'b0; cfg_out_we = 1'b0;
      run_inv(3, 5, 5, 0, 0, 0, 0, 0, 5, 1'b0, 0);
      // Reset during DRAIN after one write.
      run_inv(1, 3, 2, 0, 0, 0, 0, 0, 3, 1'b0, 1);
      @(posedge CLK); #1;
      check("abort_idle", state_idle, 1'b1);
      check("abort_compute", state_compute, 1'b0);
      check("abort_inputs_done", inputs_done, 1'b0);
      check("abort_active_ctx", active_ctx, 0);
      exp_perf_stall = 0;
      exp_perf_inv   = 0;
`ifdef NPU_SEQ_PERF_EN
      check("abort_perf_stall", perf_stall_cycles, 0);
      check("abort_perf_inv", perf_inv_count, 0);
`endif
      RST = 1'b0;
      @(posedge CLK); #1;
      // Targets were cleared by reset: ctx1 now behaves as 0/0.
      run_inv(1, 0, 0, 0, 0, 0, 0, 0, 1, 1'b0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/npu_seq_ctrl.md
Name: npu_seq_ctrl

Overview:
Parametrised next-generation NPU sequencing controller. Holds per-context input/output count targets (NUM_CTX contexts) written from the config path. Sequences one invocation at a time: read N inputs from the input FIFO, then write M outputs to the output FIFO, with explicit stall states and a completion pulse. Sits between the NPU scheduler and the input/output/config FIFOs.

Parameters:
CNT_W, 16, width of count targets and running counters
DATA_W, 16, width of cfg_data; low CNT_W bits used, CNT_W <= DATA_W
CTX_W, 2, context index width; NUM_CTX = 2**CTX_W

Ports:
CLK  in  1  clock
RST  in  1  reset, synchronous, active-high
cfg_data  in  DATA_W  config value for count registers
cfg_ctx  in  CTX_W  context targeted by config write
cfg_in_we  in  1  write input-count target of cfg_ctx
cfg_out_we  in  1  write output-count target of cfg_ctx
cfg_fifo_empty  in  1  config FIFO empty
inv_ctx  in  CTX_W  context for next invocation, sampled on IDLE->LOAD
in_fifo_empty  in  1  input FIFO empty
sched_in_rd_req  in  1  scheduler requests input read
out_fifo_full  in  1  output FIFO full
sched_out_wr_req  in  1  scheduler requests output write
in_fifo_rd_en  out  1  input FIFO pop (combinational)
out_fifo_wr_en  out  1  output FIFO push (combinational)
state_idle, state_config, state_compute, state_stall  out  1 each  one-hot state flags (compute = LOAD or DRAIN; stall = STALL_IN or STALL_OUT)
inputs_done  out  1  all inputs of current invocation consumed
inv_done  out  1  one-cycle pulse, invocation complete
active_ctx  out  CTX_W  context of current invocation

Behaviour:
- Reset: state IDLE; state_idle=1, all other outputs 0; all counters, targets, active_ctx = 0. Reset mid-invocation aborts to IDLE; no pulse.
- States: IDLE, CONFIG, LOAD, DRAIN, STALL_IN, STALL_OUT; all transitions registered.
- IDLE: !in_fifo_empty -> LOAD (priority over config); latch active_ctx=inv_ctx, in_tgt/out_tgt from that context, in_cur=out_cur=0. Else !cfg_fifo_empty -> CONFIG.
- CONFIG: cfg_in_we/cfg_out_we write context cfg_ctx; both same cycle -> both written. Writes ignored outside CONFIG. cfg_fifo_empty -> IDLE; write in that same cycle still taken.
- in_fifo_rd_en = LOAD & sched_in_rd_req & !in_fifo_empty & (in_cur != in_tgt).
- LOAD: rd_en -> in_cur+1. in_cur==in_tgt, or rd_en with in_cur+1==in_tgt -> DRAIN next cycle, inputs_done=1. in_tgt=0 -> DRAIN after one LOAD cycle, zero reads. in_fifo_empty with reads outstanding -> STALL_IN. STALL_IN -> LOAD when !in_fifo_empty.
- out_fifo_wr_en = DRAIN & sched_out_wr_req & !out_fifo_full & (out_cur != out_tgt).
- DRAIN: wr_en -> out_cur+1. Final write (or out_tgt=0 on entry) -> IDLE next cycle, inv_done=1 that cycle, inputs_done cleared. sched_out_wr_req & out_fifo_full -> STALL_OUT. STALL_OUT -> DRAIN when !out_fifo_full.
- Counters never wrap: enables gated by cur != tgt. Max target 2**CNT_W-1.
- Config changes during an invocation impossible (writes gated to CONFIG); latched targets fixed per invocation.

Optional Feature:
NPU_SEQ_PERF_EN: adds outputs perf_stall_cycles [31:0] and perf_inv_count [31:0]. Stall counter +1 each cycle in STALL_IN/STALL_OUT; inv counter +1 per inv_done; both saturate at all-ones, cleared only by RST. Without macro: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Config ctx1 in=3,out=2; invoke ctx1, FIFOs never empty/full, reqs high -> exactly 3 rd_en then 2 wr_en, inv_done pulse once, active_ctx=1, back to IDLE.
- Same, in_fifo_empty after 1st read for 4 cycles -> STALL_IN, state_stall=1, no rd_en, resume, 3 reads total; perf_stall_cycles=4 with macro.
- out_fifo_full asserted during DRAIN with req -> STALL_OUT, no wr_en until full drops, 2 writes total.
- ctx2 in=0,out=0 -> LOAD one cycle, DRAIN, inv_done, zero rd_en/wr_en.
- Config and input FIFOs both non-empty in IDLE -> LOAD taken first; CONFIG entered after invocation; cfg_in_we+cfg_out_we same cycle write both.
- RST during DRAIN after 1 of 2 writes -> IDLE next cycle, targets 0, no inv_done.
